// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: register map, status/control bit
// positions and the frame FSM state encoding.
package spi_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int BIT_E    = 8;
    localparam int BIT_RRDY = 7;
    localparam int BIT_TRDY = 6;
    localparam int BIT_TMT  = 5;
    localparam int BIT_TOE  = 4;
    localparam int BIT_ROE  = 3;
    localparam int BIT_TUE  = 2;

    // Control bits that have a matching interrupt enable (TMT has none).
    localparam logic [8:0] CTRL_MASK = 9'h1DC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with rise/fall pulses.
// Latency: STAGES clk cycles to dout, pulses coincide with the dout change.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            hist <= sync[STAGES-1];
        end
    end

    assign dout = sync[STAGES-1];
    assign rise = dout & ~hist;
    assign fall = ~dout & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with CPU register bus; optional irq via SPI_SLAVE_IRQ_EN.
// Latency: SYNC_STAGES+1 clk from pin edge to action; bus reads return next cycle.
// Backpressure: none; TRDY/RRDY flags with TOE/ROE/TUE error bits instead.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        dataavailable,
    output logic        readyfordata
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SCLK),
        .dout    (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // Select resets to its inactive level so reset never looks like a frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SS_n),
        .dout    (ss_s),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    state_t      state;
    logic [3:0]  bitcnt;
    logic [7:0]  shift;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_hold;
    logic [7:0]  tx_hold;
    logic        primed;
    logic        rrdy, trdy, toe, roe, tue;
    logic [7:0]  rx_next;
    logic [15:0] status;
    logic [15:0] rd_mux;
    logic        rd_q, wr_q, rd_p1, wr_p1;

    assign rd_p1 = ~rd_q & spi_select & ~read_n;
    assign wr_p1 = ~wr_q & spi_select & ~write_n;

    assign rx_next = {rx_sr[6:0], mosi_s};

    always_comb begin
        status           = '0;
        status[BIT_E]    = toe | roe | tue;
        status[BIT_RRDY] = rrdy;
        status[BIT_TRDY] = trdy;
        status[BIT_TMT]  = trdy & (state == IDLE);
        status[BIT_TOE]  = toe;
        status[BIT_ROE]  = roe;
        status[BIT_TUE]  = tue;
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic [8:0] ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_q && mem_addr == ADDR_CONTROL) begin
                ctrl <= data_from_cpu[8:0] & CTRL_MASK;
            end
            irq <= |(status[8:0] & ctrl);
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            ADDR_RXDATA:  rd_mux = {8'h00, rx_hold};
            ADDR_STATUS:  rd_mux = status;
`ifdef SPI_SLAVE_IRQ_EN
            ADDR_CONTROL: rd_mux = {7'd0, ctrl};
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            data_to_cpu <= '0;
        end else begin
            rd_q <= rd_p1;
            wr_q <= wr_p1;
            if (rd_p1) begin
                data_to_cpu <= rd_mux;
            end
        end
    end

    // CPU-side updates come first so that same-cycle FSM flag sets win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shift   <= '0;
            rx_sr   <= '0;
            rx_hold <= '0;
            tx_hold <= '0;
            primed  <= 1'b0;
            rrdy    <= 1'b0;
            trdy    <= 1'b1;
            toe     <= 1'b0;
            roe     <= 1'b0;
            tue     <= 1'b0;
            MISO    <= 1'b0;
        end else begin
            if (wr_q) begin
                case (mem_addr)
                    ADDR_TXDATA: begin
                        if (trdy) begin
                            tx_hold <= data_from_cpu[7:0];
                            primed  <= 1'b1;
                            trdy    <= 1'b0;
                        end else begin
                            toe <= 1'b1;
                        end
                    end
                    ADDR_STATUS: begin
                        rrdy <= 1'b0;
                        toe  <= 1'b0;
                        roe  <= 1'b0;
                        tue  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (rd_p1 && mem_addr == ADDR_RXDATA) begin
                rrdy <= 1'b0;
            end

            if (ss_rise) begin
                state  <= IDLE;
                bitcnt <= '0;
                MISO   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        MISO <= 1'b0;
                        if (!ss_s) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (primed) begin
                            shift  <= tx_hold;
                            primed <= 1'b0;
                            trdy   <= 1'b1;
                            MISO   <= tx_hold[7];
                        end else begin
                            shift  <= IDLE_BYTE;
                            tue    <= 1'b1;
                            MISO   <= IDLE_BYTE[7];
                        end
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            rx_sr  <= rx_next;
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd7) begin
                                rx_hold <= rx_next;
                                rrdy    <= 1'b1;
                                if (rrdy) begin
                                    roe <= 1'b1;
                                end
                                state <= LOAD;
                            end
                        end else if (sclk_fall && bitcnt != 4'd0 && bitcnt <= 4'd7) begin
                            shift <= {shift[6:0], 1'b0};
                            MISO  <= shift[6];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign MISO_oe       = (state != IDLE);
    assign dataavailable = rrdy;
    assign readyfordata  = trdy;

    logic unused_bits;
    assign unused_bits = ^{sclk_s, ss_fall, data_from_cpu[15:8]};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a task-level SPI master and CPU bus driver, with
// queued expected MISO/rx bytes compared as each frame completes.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO, MISO_oe;
    logic [2:0]  mem_addr = '0;
    logic [15:0] data_from_cpu = '0;
    logic [15:0] data_to_cpu;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic        spi_select = 1'b0;
    logic        dataavailable, readyfordata;
`ifdef SPI_SLAVE_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_miso[$];
    logic [7:0] exp_rx[$];

    spi_slave #(.IDLE_BYTE(8'hFF), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SCLK          (SCLK),
        .SS_n          (SS_n),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .MISO_oe       (MISO_oe),
        .mem_addr      (mem_addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .read_n        (read_n),
        .write_n       (write_n),
        .spi_select    (spi_select),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata)
`ifdef SPI_SLAVE_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        tick(2);
        write_n = 1'b1; spi_select = 1'b0;
        tick(1);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        tick(1);
        d = data_to_cpu;
        tick(1);
        read_n = 1'b1; spi_select = 1'b0;
        tick(1);
    endtask

    // Mode 0 master: MOSI set while SCLK low, MISO sampled just before the rise.
    // Leaves SCLK high after the last bit.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            tick(HALF);
            got = {got[6:0], MISO};
            SCLK = 1'b1;
            if (i != nbits - 1) begin
                tick(HALF);
                SCLK = 1'b0;
            end
        end
    endtask

    task automatic ss_start();
        SS_n = 1'b0;
        tick(8);
    endtask

    task automatic next_byte();
        tick(HALF);
        SCLK = 1'b0;
    endtask

    // fast=1 deselects one clk after the last rise so no trailing LOAD runs.
    task automatic ss_end(input bit fast);
        if (fast) begin
            tick(1);
            SS_n = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end else begin
            tick(HALF);
            SCLK = 1'b0;
            tick(HALF);
            SS_n = 1'b1;
        end
        tick(8);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        tick(3);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b want 0", MISO_oe); end
        checks++; if (data_to_cpu !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", data_to_cpu); end
        checks++; if (dataavailable !== 1'b0) begin errors++; $display("FAIL reset_rrdy got %b want 0", dataavailable); end
        checks++; if (readyfordata !== 1'b1) begin errors++; $display("FAIL reset_trdy got %b want 1", readyfordata); end
        reset_n = 1'b1;
        tick(4);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL reset_status got %h want 0060", d); end
    endtask

    task automatic test_basic();
        logic [7:0] got, e;
        logic [15:0] d;
        cpu_write(ADDR_TXDATA, 16'h00A5);
        exp_miso.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        ss_start();
        spi_bits(8'h3C, 8, got);
        ss_end(1'b1);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL basic_miso got %h want %h", got, e); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h00E0) begin errors++; $display("FAIL basic_status got %h want 00E0", d); end
        cpu_read(ADDR_RXDATA, d);
        e = exp_rx.pop_front();
        checks++; if (d !== {8'h00, e}) begin errors++; $display("FAIL basic_rx got %h want %h", d, {8'h00, e}); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL basic_status_after_read got %h want 0060", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e;
        logic [15:0] d;
        cpu_write(ADDR_TXDATA, 16'h0081);
        exp_miso.push_back(8'h81);
        exp_miso.push_back(8'hFF);
        ss_start();
        spi_bits(8'h11, 8, got);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_miso0 got %h want %h", got, e); end
        next_byte();
        spi_bits(8'h22, 8, got);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_miso1 got %h want %h", got, e); end
        ss_end(1'b0);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h01EC) begin errors++; $display("FAIL b2b_status got %h want 01EC", d); end
        cpu_write(ADDR_STATUS, 16'h0000);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL b2b_status_clear got %h want 0060", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] got, e;
        logic [15:0] d;
        cpu_write(ADDR_TXDATA, 16'h000F);
        exp_miso.push_back(8'h0F);
        exp_rx.push_back(8'h5A);
        ss_start(); spi_bits(8'h5A, 8, got); ss_end(1'b1);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ovr_miso0 got %h want %h", got, e); end
        cpu_write(ADDR_TXDATA, 16'h00F0);
        exp_miso.push_back(8'hF0);
        exp_rx.push_back(8'hA5);
        ss_start(); spi_bits(8'hA5, 8, got); ss_end(1'b1);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ovr_miso1 got %h want %h", got, e); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h01E8) begin errors++; $display("FAIL ovr_status got %h want 01E8", d); end
        // rx_hold keeps only the newest byte
        void'(exp_rx.pop_front());
        e = exp_rx.pop_front();
        cpu_read(ADDR_RXDATA, d);
        checks++; if (d !== {8'h00, e}) begin errors++; $display("FAIL ovr_rx got %h want %h", d, {8'h00, e}); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0168) begin errors++; $display("FAIL ovr_status_after_read got %h want 0168", d); end
        cpu_write(ADDR_STATUS, 16'h0000);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL ovr_status_clear got %h want 0060", d); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] got, e;
        logic [15:0] d;
        cpu_write(ADDR_TXDATA, 16'h0042);
        exp_miso.push_back(8'h42);
        cpu_write(ADDR_TXDATA, 16'h0099);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0110) begin errors++; $display("FAIL toe_status got %h want 0110", d); end
        ss_start(); spi_bits(8'h77, 8, got); ss_end(1'b1);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL toe_miso got %h want %h", got, e); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h01F0) begin errors++; $display("FAIL toe_status_after got %h want 01F0", d); end
        cpu_write(ADDR_STATUS, 16'h0000);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL toe_status_clear got %h want 0060", d); end
    endtask

    task automatic test_partial();
        logic [7:0] got, e;
        logic [15:0] d;
        int n;
        ss_start();
        spi_bits(8'hF0, 4, got);
        checks++; if (got[3:0] !== 4'hF) begin errors++; $display("FAIL part_miso got %h want F", got[3:0]); end
        tick(HALF);
        SCLK = 1'b0;
        tick(HALF);
        checks++; if (MISO_oe !== 1'b1) begin errors++; $display("FAIL part_oe_on got %b want 1", MISO_oe); end
        SS_n = 1'b1;
        n = 0;
        while (MISO_oe !== 1'b0 && n < 3 + SYNC) begin
            tick(1);
            n++;
        end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL part_oe_off got %b want 0 after %0d cycles", MISO_oe, n); end
        tick(8);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0164) begin errors++; $display("FAIL part_status got %h want 0164", d); end
        cpu_write(ADDR_STATUS, 16'h0000);
        cpu_write(ADDR_TXDATA, 16'h005A);
        exp_miso.push_back(8'h5A);
        exp_rx.push_back(8'hC3);
        ss_start(); spi_bits(8'hC3, 8, got); ss_end(1'b1);
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL part_next_miso got %h want %h", got, e); end
        cpu_read(ADDR_RXDATA, d);
        e = exp_rx.pop_front();
        checks++; if (d !== {8'h00, e}) begin errors++; $display("FAIL part_next_rx got %h want %h", d, {8'h00, e}); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL part_next_status got %h want 0060", d); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        logic [15:0] d;
        cpu_write(ADDR_TXDATA, 16'h0033);
        ss_start();
        spi_bits(8'h00, 3, got);
        reset_n = 1'b0;
        #1;
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", MISO_oe); end
        checks++; if (readyfordata !== 1'b1) begin errors++; $display("FAIL rstmid_trdy got %b want 1", readyfordata); end
        tick(2);
        SCLK = 1'b0;
        SS_n = 1'b1;
        reset_n = 1'b1;
        tick(8);
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL rstmid_status got %h want 0060", d); end
    endtask

`ifdef SPI_SLAVE_IRQ_EN
    task automatic test_irq();
        logic [7:0] got, e;
        logic [15:0] d;
        cpu_write(ADDR_CONTROL, 16'h0080);
        cpu_read(ADDR_CONTROL, d);
        checks++; if (d !== 16'h0080) begin errors++; $display("FAIL irq_ctrl got %h want 0080", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        cpu_write(ADDR_TXDATA, 16'h0012);
        exp_miso.push_back(8'h12);
        fork
            begin
                ss_start(); spi_bits(8'h9E, 8, got); ss_end(1'b1);
            end
            begin
                int n;
                n = 0;
                while (dataavailable !== 1'b1 && n < 2000) begin
                    tick(1);
                    n++;
                end
                checks++; if (dataavailable !== 1'b1) begin errors++; $display("FAIL irq_rrdy_timeout got %b want 1", dataavailable); end
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_same_cycle got %b want 0", irq); end
                tick(1);
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_next_cycle got %b want 1", irq); end
            end
        join
        e = exp_miso.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL irq_miso got %h want %h", got, e); end
        cpu_read(ADDR_RXDATA, d);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read got %b want 0", irq); end
    endtask
`else
    task automatic test_irq();
        logic [15:0] d;
        cpu_write(ADDR_CONTROL, 16'hFFFF);
        cpu_read(ADDR_CONTROL, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_absent got %h want 0000", d); end
        cpu_read(ADDR_STATUS, d);
        checks++; if (d !== 16'h0060) begin errors++; $display("FAIL ctrl_absent_status got %h want 0060", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_tx_overflow();
        test_partial();
        test_reset_midframe();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder (slave) for mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. It is the far-end counterpart of the spi_master CPU peripheral and sits on the same 16-bit CPU register bus. SCLK, SS_n and MOSI are asynchronous inputs, oversampled in the clk domain. Received bytes go to an rx holding register; reply bytes come from a tx holding register loaded by the CPU.

Parameters:
IDLE_BYTE, 8'hFF, byte shifted out on MISO when the tx holding register is empty at byte start (underrun).
SYNC_STAGES, 2, synchronizer depth for SCLK/SS_n/MOSI; legal range 2..3.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock from master, asynchronous
SS_n  in  1  slave select, active low, asynchronous
MOSI  in  1  master-out data
MISO  out  1  slave-out data
MISO_oe  out  1  MISO output enable, high while selected
mem_addr  in  3  register address: 0 rxdata r, 1 txdata w, 2 status r/w, 3 control r/w
data_from_cpu  in  16  write data
data_to_cpu  out  16  read data, registered
read_n  in  1  read strobe, active low
write_n  in  1  write strobe, active low
spi_select  in  1  chip select for the register bus
dataavailable  out  1  equals RRDY
readyfordata  out  1  equals TRDY

Behaviour:
- Interface: one clock, clk. Asynchronous active-low reset, reset_n.
- Reset values: all registers 0; MISO=0, MISO_oe=0, data_to_cpu=0, RRDY=0, TRDY=1, state=IDLE.
- Bus access: two-cycle, with strobe = ~strobe_q & spi_select & ~n.
  - Reads: data_to_cpu is valid the cycle after the p1 strobe.
  - Writes: act on the registered strobe.
- Status word: bit8 E=TOE|ROE|TUE, bit7 RRDY, bit6 TRDY, bit5 TMT, bit4 TOE, bit3 ROE, bit2 TUE. Other bits are 0.
  - TMT=TRDY&(state==IDLE).
  - Any status write clears RRDY, TOE, ROE and TUE.
- txdata write with TRDY=1: tx_hold<=data[7:0], primed=1, TRDY=0. Write with TRDY=0: data is dropped and TOE<=1.
- rxdata read: returns rx_hold and clears RRDY the cycle after the p1 strobe.
- Synchronization: SYNC_STAGES flops, plus one history flop on SCLK and SS_n for edge detection.
  - Constraint: SCLK high and low times must each be at least 4 clk periods.
  - Constraint: SS_n fall to first SCLK rise must be at least 4 clk periods.
- FSM:
  - IDLE: wait for synchronized SS_n low. Then go to LOAD.
  - LOAD (1 cycle):
    - If primed: shift<=tx_hold and primed<=0.
    - Else: shift<=IDLE_BYTE and TUE<=1.
    - Set bitcnt<=0, MISO<=shift msb. Go to SHIFT.
  - SHIFT, SCLK rising edge: rx_sr<={rx_sr[6:0],MOSI_s}, bitcnt++.
    - When bitcnt reaches 8: rx_hold<=next rx_sr, RRDY<=1, and ROE<=1 if RRDY was already 1 (rx_hold is overwritten anyway). Go to LOAD for a back-to-back byte.
  - SHIFT, SCLK falling edge with bitcnt in 1..7: shift<<=1 and MISO<=next bit.
- MISO_oe=1 in LOAD and SHIFT, 0 in IDLE.
- SS_n rise in any state: return to IDLE the next cycle; bitcnt<=0; MISO<=0. A partial byte is discarded with no RRDY and no ROE. A consumed tx byte is not restored.
- A CPU tx write in the same cycle as LOAD: LOAD takes the old primed state. The write lands after, unless primed was 1, in which case TOE is set.
- Reset mid-frame: returns to IDLE immediately. The frame is lost.

Optional Feature:
SPI_SLAVE_IRQ_EN.
- Defined: adds output irq (1 bit) and a control register at addr 3, bits 8 iE, 7 iRRDY, 6 iTRDY, 4 iTOE, 3 iROE, 2 iTUE.
  - irq is registered: OR of each status bit ANDed with its enable.
  - Reset values: irq=0, enables=0.
- Undefined: no irq port. addr 3 reads 0 and writes are ignored.

Decomposition:
- Package spi_pkg: register address constants (ADDR_RXDATA..ADDR_CONTROL), status/control bit index constants, and the FSM state typedef (IDLE, LOAD, SHIFT).
- One sub-module, spi_sync_edge: N-stage synchronizer with rise/fall pulse outputs, instantiated for SCLK and SS_n. MOSI uses synchronizer output only.

Test Plan:
- Write txdata 0x00A5, assert SS_n, master sends 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_hold=0x3C; RRDY=1; status=0x00E0.
- Two back-to-back bytes under one SS_n, second tx not written -> second MISO byte 0xFF; TUE=1; E=1.
- Receive 2 bytes without reading rxdata -> ROE=1; rxdata read returns the second byte; a status write then clears ROE/TUE/RRDY.
- Write txdata twice without a frame -> second write sets TOE=1; tx_hold keeps the first value.
- SS_n released after 4 bits -> RRDY stays 0; MISO_oe=0 within 3+SYNC_STAGES cycles; the next frame starts cleanly at bit 0.
- With SPI_SLAVE_IRQ_EN: enable iRRDY, receive a byte -> irq=1 one cycle after RRDY; an rxdata read drops irq.
